// File: rtl/gc_scheduler.sv
// Garbage-collection sequencing controller: select victim, scan/relocate valid pages, erase, recover.
// Optional GC_STATS_EN adds saturating moved_pages / erased_blocks counters.
module gc_scheduler #(
    parameter int unsigned BLOCK_W = 8,
    parameter int unsigned PAGE_W  = 6,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned LOW_WM  = 2,
    parameter int unsigned HIGH_WM = 4
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [CNT_W-1:0]   clean_num,
    input  logic               host_busy,
    output logic               victim_req,
    input  logic               victim_valid,
    input  logic [BLOCK_W-1:0] victim_blk,
    input  logic               page_valid,
    output logic [BLOCK_W-1:0] cur_blk,
    output logic [PAGE_W-1:0]  cur_page,
    output logic               mv_req,
    input  logic               mv_ack,
    output logic               erase_req,
    input  logic               erase_ack,
    output logic               fifo_recover_en,
    output logic [BLOCK_W-1:0] recover_blk,
    output logic               gc_active,
    output logic               gc_urgent,
    output logic               gc_done
`ifdef GC_STATS_EN
    ,
    output logic [15:0]        moved_pages,
    output logic [15:0]        erased_blocks
`endif
);

    localparam int unsigned LAST_PAGE = (1 << PAGE_W) - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        SCAN    = 3'd2,
        MOVE    = 3'd3,
        ERASE   = 3'd4,
        RECOVER = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [BLOCK_W-1:0]   blk_d;
    logic [PAGE_W-1:0]    page_d;
    logic                 urgent_q, urgent_d;
    logic                 done_d;

    logic                 clean_zero;
    logic                 clean_low;
    logic [CNT_W:0]       clean_inc;
    logic                 last_page;
    logic                 stall;

    assign clean_zero = (clean_num == '0);
    assign clean_low  = (clean_num <= CNT_W'(LOW_WM));
    assign clean_inc  = {1'b0, clean_num} + (CNT_W+1)'(1);
    assign last_page  = (cur_page == PAGE_W'(LAST_PAGE));
    assign stall      = host_busy && !urgent_q;

    // Requests are decoded from state so they drop the cycle after their ack is taken
    assign victim_req      = (state_q == SELECT);
    assign mv_req          = (state_q == MOVE);
    assign erase_req       = (state_q == ERASE);
    assign fifo_recover_en = (state_q == RECOVER);
    assign recover_blk     = fifo_recover_en ? cur_blk : '0;
    assign gc_active       = (state_q != IDLE);
    assign gc_urgent       = urgent_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cur_blk  <= '0;
            cur_page <= '0;
            urgent_q <= 1'b0;
            gc_done  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_blk  <= blk_d;
            cur_page <= page_d;
            urgent_q <= urgent_d;
            gc_done  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        blk_d    = cur_blk;
        page_d   = cur_page;
        urgent_d = urgent_q;
        done_d   = 1'b0;

        // An exhausted pool forces urgent mode for the rest of this reclaim
        if (state_q != IDLE && clean_zero) begin
            urgent_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (clean_zero) begin
                    state_d  = SELECT;
                    urgent_d = 1'b1;
                end else if (clean_low && !host_busy) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (victim_valid) begin
                    blk_d   = victim_blk;
                    page_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!stall) begin
                    if (page_valid) begin
                        state_d = MOVE;
                    end else if (last_page) begin
                        state_d = ERASE;
                    end else begin
                        page_d = cur_page + PAGE_W'(1);
                    end
                end
            end
            MOVE: begin
                if (mv_ack) begin
                    if (last_page) begin
                        state_d = ERASE;
                    end else begin
                        page_d  = cur_page + PAGE_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            ERASE: begin
                if (erase_ack) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                urgent_d = 1'b0;
                if (clean_inc < (CNT_W+1)'(HIGH_WM)) begin
                    state_d = SELECT;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef GC_STATS_EN
    // Saturating activity counters
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            moved_pages   <= '0;
            erased_blocks <= '0;
        end else begin
            if (state_q == MOVE && mv_ack && moved_pages != 16'hFFFF) begin
                moved_pages <= moved_pages + 16'd1;
            end
            if (state_q == RECOVER && erased_blocks != 16'hFFFF) begin
                erased_blocks <= erased_blocks + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/gc_scheduler.md
# gc_scheduler

Sequencing controller for NVM garbage collection. Decides when to reclaim a block from the clean-block count, then runs each reclaim: fetch victim, scan pages, relocate valid pages, erase, return the erased block to the clean-block FIFO through the recover path. It yields to host writes at page boundaries unless the free pool is exhausted. It sits between the garbage collection datapath (clean FIFO, recover port), the victim selector, the page mover and the erase engine.

## Interface
- BLOCK_W, 8, block address width (matches block_t)
- PAGE_W, 6, page index width; pages per block = 2^PAGE_W
- CNT_W, 5, clean_num width
- LOW_WM, 2, start GC when clean_num <= LOW_WM
- HIGH_WM, 4, keep reclaiming while clean_num + 1 < HIGH_WM

- CLK  in  1  clock; all logic on rising edge
- nRST  in  1  reset; synchronous and active-low
- clean_num  in  CNT_W  current clean-block count from garbage collection
- host_busy  in  1  host write outstanding
- victim_req  out  1  request a victim block
- victim_valid  in  1  victim_blk valid (ack)
- victim_blk  in  BLOCK_W  selected victim
- page_valid  in  1  valid bit of (cur_blk, cur_page); combinational lookup
- cur_blk  out  BLOCK_W  block under reclaim
- cur_page  out  PAGE_W  page under scan
- mv_req  out  1  relocate page cur_page of cur_blk
- mv_ack  in  1  relocation complete
- erase_req  out  1  erase cur_blk
- erase_ack  in  1  erase complete
- fifo_recover_en  out  1  one-cycle pulse: push recover_blk into clean FIFO
- recover_blk  out  BLOCK_W  erased block
- gc_active  out  1  state != IDLE
- gc_urgent  out  1  reclaim running in urgent mode
- gc_done  out  1  one-cycle pulse on return to IDLE

## Operation
- States: IDLE, SELECT, SCAN, MOVE, ERASE, RECOVER.
- IDLE: if clean_num == 0 -> SELECT, urgent set. Else if clean_num <= LOW_WM and !host_busy -> SELECT. Else stay.
- SELECT: victim_req = 1. On victim_valid: latch victim_blk into cur_blk, cur_page = 0, -> SCAN.
- SCAN: if host_busy and !urgent, stall (hold cur_page). Else if page_valid -> MOVE. Else if cur_page == 2^PAGE_W-1 -> ERASE. Else cur_page++.
- MOVE: mv_req = 1 until mv_ack. On ack: last page -> ERASE, else cur_page++ and -> SCAN. No preemption inside MOVE.
- ERASE: erase_req = 1 until erase_ack -> RECOVER.
- RECOVER: fifo_recover_en = 1, recover_blk = cur_blk for exactly one cycle. Then if clean_num + 1 < HIGH_WM -> SELECT, keeping urgent only if clean_num + 1 == 0 (never true, so urgent clears). Else -> IDLE with gc_done pulse and urgent cleared.
- urgent: set on IDLE->SELECT when clean_num == 0. Sticky until RECOVER. Also set from any non-IDLE state when clean_num == 0 is sampled.
- Compare clean_num + 1 at CNT_W+1 bits; no wrap.
- Handshakes: req is held high until ack is sampled high and deasserts the following cycle. An ack while req is low is ignored. Only one of victim_req, mv_req and erase_req is high at a time.
- Reset: nRST low at a clock edge -> IDLE; cur_blk, cur_page and urgent = 0. Any in-flight request drops on the next cycle with no completion.

## Timing
- All outputs are registered or decoded from registered state. Reset value of every output is 0.
- IDLE->SELECT: 1 cycle after the trigger is sampled. victim_req is high in the first SELECT cycle.
- An invalid page costs 1 SCAN cycle. A valid page costs 1 SCAN cycle + MOVE until ack + 1.
- Empty victim (all pages invalid), zero-latency acks: 1 SELECT + 2^PAGE_W SCAN + 1 ERASE + 1 RECOVER cycles.
- fifo_recover_en is asserted 1 cycle after erase_ack is sampled.
- gc_done is asserted in the first IDLE cycle after RECOVER.

## Configuration
- GC_STATS_EN defined: adds outputs moved_pages (16-bit) and erased_blocks (16-bit).
  - moved_pages increments on each mv_ack accepted in MOVE; erased_blocks increments on each RECOVER.
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset mid-MOVE: with mv_req high, drive nRST=0 for 1 cycle -> next cycle all outputs 0, state IDLE, cur_page 0.
- Threshold start: clean_num=3 -> no victim_req. Drop to 2 with host_busy=0 -> victim_req high next cycle. Victim 0x15 has valid pages 3 and 63 -> exactly two mv_req episodes at cur_page 3 and 63, then erase_req. RECOVER pulses fifo_recover_en with recover_blk=0x15; clean_num=3 at RECOVER -> gc_done, IDLE.
- Host yield: clean_num=2, host_busy held high for 10 cycles during SCAN at page 5 -> cur_page stays 5. Resumes at 6 the cycle after host_busy falls. No trigger from IDLE while host_busy=1.
- Urgent: clean_num=0 with host_busy=1 -> SELECT anyway, gc_urgent=1, SCAN never stalls. gc_urgent clears after RECOVER.
- Multi-block: clean_num=1 held -> two back-to-back reclaims with no IDLE between them (RECOVER->SELECT). clean_num=3 at second RECOVER -> IDLE.
- Handshake: spurious mv_ack/erase_ack during SCAN are ignored. Victim with all pages invalid and 1-cycle acks completes in 2^PAGE_W+3 cycles from SELECT.
